seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl : multiplexed 7-segment scanner with PWM dimming, blinking,
//                 leading-zero blanking and frame-synchronous (tear-free) load
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int PWM_BITS     = 3,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                    display_clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic [N_DIGITS-1:0]     blink_mask,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [N_DIGITS-1:0]     an_n,
  output logic                    frame_done
);

  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] c_last_digit = DW'(N_DIGITS - 1);
  localparam logic [FW-1:0] c_last_frame = FW'(BLINK_FRAMES - 1);

  logic [PWM_BITS-1:0]   slot_q,       slot_d;
  logic [DW-1:0]         digit_q,      digit_d;
  logic [FW-1:0]         frame_cnt_q,  frame_cnt_d;
  logic                  phase_q,      phase_d;
  logic                  pending_q,    pending_d;
  logic [4*N_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [N_DIGITS-1:0]   shadow_dp_q,  shadow_dp_d;
  logic [4*N_DIGITS-1:0] active_val_q, active_val_d;
  logic [N_DIGITS-1:0]   active_dp_q,  active_dp_d;
  logic [6:0]            seg_n_q,      seg_n_d;
  logic                  dp_n_q,       dp_n_d;
  logic [N_DIGITS-1:0]   an_n_q,       an_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  w_slot_wrap;
  logic                  w_frame_wrap;
  logic [N_DIGITS-1:0]   w_lz_blank;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic                  w_blink;
  logic                  w_lzb;
  logic [N_DIGITS-1:0]   w_an_sel;
  logic                  w_lit;
  logic [6:0]            w_glyph;

  // Scan counters, blink timing and the shadow/active handoff.
  always_comb begin
    w_slot_wrap  = &slot_q;
    w_frame_wrap = w_slot_wrap && (digit_q == c_last_digit);

    slot_d      = slot_q + 1'b1;
    digit_d     = digit_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (w_slot_wrap) begin
      digit_d = (digit_q == c_last_digit) ? '0 : digit_q + 1'b1;
    end
    if (w_frame_wrap) begin
      if (frame_cnt_q == c_last_frame) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // Boundary commit happens before the load so a coincident load stays pending.
    pending_d    = pending_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    if (w_frame_wrap && pending_q) begin
      active_val_d = shadow_val_q;
      active_dp_d  = shadow_dp_q;
      pending_d    = 1'b0;
    end
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end
  end

  // Leading-zero run from the most significant digit; digit 0 is never blanked.
  always_comb begin
    logic lz_run;
    w_lz_blank = '0;
    lz_run     = blank_lz;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      lz_run        = lz_run && (active_val_q[4*k +: 4] == 4'h0) && !active_dp_q[k];
      w_lz_blank[k] = lz_run;
    end
  end

  always_comb begin
    w_nib    = 4'h0;
    w_dp     = 1'b0;
    w_blink  = 1'b0;
    w_lzb    = 1'b0;
    w_an_sel = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (digit_q == DW'(k)) begin
        w_nib       = active_val_q[4*k +: 4];
        w_dp        = active_dp_q[k];
        w_blink     = blink_mask[k];
        w_lzb       = w_lz_blank[k];
        w_an_sel[k] = 1'b0;
      end
    end

    case (w_nib)
      4'h0:    w_glyph = 7'b0000001;
      4'h1:    w_glyph = 7'b1001111;
      4'h2:    w_glyph = 7'b0010010;
      4'h3:    w_glyph = 7'b0000110;
      4'h4:    w_glyph = 7'b1001100;
      4'h5:    w_glyph = 7'b0100100;
      4'h6:    w_glyph = 7'b0100000;
      4'h7:    w_glyph = 7'b0001111;
      4'h8:    w_glyph = 7'b0000000;
      4'h9:    w_glyph = 7'b0000100;
      4'hA:    w_glyph = 7'b0001000;
      4'hB:    w_glyph = 7'b1100000;
      4'hC:    w_glyph = 7'b0110001;
      4'hD:    w_glyph = 7'b1000010;
      4'hE:    w_glyph = 7'b0110000;
      default: w_glyph = 7'b0111000;
    endcase

    w_lit = en && (slot_q <= brightness) && !w_lzb && !(phase_q && w_blink);

    an_n_d       = w_lit ? w_an_sel : '1;
    seg_n_d      = w_lit ? w_glyph : 7'h7F;
    dp_n_d       = w_lit ? ~w_dp : 1'b1;
    frame_done_d = w_frame_wrap;
  end

  always_ff @(posedge display_clk or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      digit_q      <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
      pending_q    <= 1'b0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      digit_q      <= digit_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      pending_q    <= pending_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire
